// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with a first-word-fall-through read port,
// occupancy count, programmable almost flags and overflow/underflow reporting.
//
// +----------------------------------------------------------------------------+
// | Module      : fifo_param                                                   |
// | Description : WIDTH x DEPTH synchronous FIFO, FWFT output, any DEPTH >= 2. |
// |               Build macro FIFO_STICKY_ERR_EN makes overflow/underflow      |
// |               sticky until reset.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int             CW       = $clog2(DEPTH + 1);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic             ovf_evt, udf_evt;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A push into a full FIFO is still taken when a pop frees the head slot.
    assign wr_acc  = push & (~full | pop);
    assign rd_acc  = pop & ~empty;
    assign ovf_evt = push & full & ~pop;
    assign udf_evt = pop & empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef FIFO_STICKY_ERR_EN
        overflow_d  = overflow_q | ovf_evt;
        underflow_d = underflow_q | udf_evt;
`else
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign out          = empty ? '0 : mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (int'(count_q) >= AF_THRESH);
    assign almost_empty = (int'(count_q) <= AE_THRESH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed checks of fifo_param in three configurations
// (2x4 lab-sized, 8x5 non-power-of-two, 8x8 with custom thresholds).
//
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_param                                                |
// | Description : Directed vectors with hand-computed expectations.            |
// |               Honours FIFO_STICKY_ERR_EN for error-flag expectations.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_param;

`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DUT A: WIDTH=2, DEPTH=4, default thresholds (AF=3, AE=1)
    logic [1:0] in_a = '0, out_a;
    logic       push_a = 1'b0, pop_a = 1'b0;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [2:0] cnt_a;

    fifo_param #(.WIDTH(2), .DEPTH(4)) u_dut_a (
        .clk(clk), .reset(rst_n), .in(in_a), .push(push_a), .pop(pop_a),
        .out(out_a), .full(full_a), .empty(empty_a), .count(cnt_a),
        .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(udf_a)
    );

    // DUT B: WIDTH=8, DEPTH=5
    logic [7:0] in_b = '0, out_b;
    logic       push_b = 1'b0, pop_b = 1'b0;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [2:0] cnt_b;

    fifo_param #(.WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk(clk), .reset(rst_n), .in(in_b), .push(push_b), .pop(pop_b),
        .out(out_b), .full(full_b), .empty(empty_b), .count(cnt_b),
        .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(udf_b)
    );

    // DUT C: WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2
    logic [7:0] in_c = '0, out_c;
    logic       push_c = 1'b0, pop_c = 1'b0;
    logic       full_c, empty_c, af_c, ae_c, ovf_c, udf_c;
    logic [3:0] cnt_c;

    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_dut_c (
        .clk(clk), .reset(rst_n), .in(in_c), .push(push_c), .pop(pop_c),
        .out(out_c), .full(full_c), .empty(empty_c), .count(cnt_c),
        .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c), .underflow(udf_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic ps, input logic pp, input logic [1:0] d);
        push_a = ps; pop_a = pp; in_a = d;
        @(posedge clk); #1;
        push_a = 1'b0; pop_a = 1'b0;
    endtask

    task automatic step_b(input logic ps, input logic pp, input logic [7:0] d);
        push_b = ps; pop_b = pp; in_b = d;
        @(posedge clk); #1;
        push_b = 1'b0; pop_b = 1'b0;
    endtask

    task automatic step_c(input logic ps, input logic pp, input logic [7:0] d);
        push_c = ps; pop_c = pp; in_c = d;
        @(posedge clk); #1;
        push_c = 1'b0; pop_c = 1'b0;
    endtask

    initial begin
        logic [1:0] seq_a [4];
        logic [1:0] seq_a2 [4];
        logic [7:0] seq_b [5];
        seq_a  = '{2'd1, 2'd2, 2'd3, 2'd3};
        seq_a2 = '{2'd2, 2'd3, 2'd3, 2'd2};
        seq_b  = '{8'hA3, 8'hA4, 8'hB0, 8'hB1, 8'hB2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",   32'(out_a),   32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_full",  32'(full_a),  32'd0);
        check("rst_count", 32'(cnt_a),   32'd0);
        check("rst_af",    32'(af_a),    32'd0);
        check("rst_ae",    32'(ae_a),    32'd1);
        check("rst_ovf",   32'(ovf_a),   32'd0);
        check("rst_udf",   32'(udf_a),   32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        step_a(1, 0, 2'd1);
        step_a(1, 0, 2'd2);
        step_a(1, 0, 2'd3);
        check("pre_rst_count", 32'(cnt_a), 32'd3);
        rst_n = 1'b0;
        #1;
        check("arst_out",   32'(out_a),   32'd0);
        check("arst_empty", 32'(empty_a), 32'd1);
        check("arst_full",  32'(full_a),  32'd0);
        check("arst_count", 32'(cnt_a),   32'd0);
        #2 rst_n = 1'b1;
        step_a(1, 0, 2'd1);
        check("post_rst_out",   32'(out_a), 32'd1);
        check("post_rst_count", 32'(cnt_a), 32'd1);
        step_a(0, 1, 2'd0);
        check("drain_empty", 32'(empty_a), 32'd1);

        // Fill and order, overflow pulse
        for (int i = 0; i < 4; i++) step_a(1, 0, seq_a[i]);
        check("fill_full",  32'(full_a), 32'd1);
        check("fill_count", 32'(cnt_a),  32'd4);
        check("fill_af",    32'(af_a),   32'd1);
        check("fill_out",   32'(out_a),  32'd1);
        step_a(1, 0, 2'd0);
        check("ovf_count", 32'(cnt_a), 32'd4);
        check("ovf_pulse", 32'(ovf_a), 32'd1);
        check("ovf_head",  32'(out_a), 32'd1);
        step_a(0, 0, 2'd0);
        check("ovf_after", 32'(ovf_a), 32'(STICKY));
        for (int i = 0; i < 4; i++) begin
            check("pop_order", 32'(out_a), 32'(seq_a[i]));
            step_a(0, 1, 2'd0);
        end
        check("popped_empty", 32'(empty_a), 32'd1);
        check("popped_out",   32'(out_a),   32'd0);
        check("popped_udf",   32'(udf_a),   32'd0);

        // Simultaneous push/pop at full
        for (int i = 0; i < 4; i++) step_a(1, 0, seq_a[i]);
        step_a(1, 1, 2'd2);
        check("pp_full_count", 32'(cnt_a), 32'd4);
        check("pp_full_out",   32'(out_a), 32'd2);
        check("pp_full_ovf",   32'(ovf_a), 32'(STICKY));
        for (int i = 0; i < 4; i++) begin
            check("pp_pop_order", 32'(out_a), 32'(seq_a2[i]));
            step_a(0, 1, 2'd0);
        end
        check("pp_drained", 32'(empty_a), 32'd1);

        // Simultaneous push/pop at empty
        step_a(1, 1, 2'd3);
        check("pe_count", 32'(cnt_a), 32'd1);
        check("pe_out",   32'(out_a), 32'd3);
        check("pe_udf",   32'(udf_a), 32'd1);
        step_a(0, 1, 2'd0);
        check("pe_udf_next", 32'(udf_a), 32'(STICKY));

        // Pop on empty: underflow behaviour over subsequent valid traffic
        step_a(0, 1, 2'd0);
        check("udf_set",   32'(udf_a),   32'd1);
        check("udf_out",   32'(out_a),   32'd0);
        check("udf_count", 32'(cnt_a),   32'd0);
        for (int i = 0; i < 10; i++) begin
            step_a(1, 0, 2'(i));
            step_a(0, 1, 2'd0);
            check("udf_hold", 32'(udf_a), 32'(STICKY));
        end
        rst_n = 1'b0;
        #1;
        check("udf_rst", 32'(udf_a), 32'd0);
        check("ovf_rst", 32'(ovf_a), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-power-of-two wrap
        for (int i = 0; i < 5; i++) step_b(1, 0, 8'hA0 + 8'(i));
        check("b_full5", 32'(full_b), 32'd1);
        for (int i = 0; i < 3; i++) step_b(0, 1, 8'h00);
        check("b_head", 32'(out_b), 32'hA3);
        for (int i = 0; i < 3; i++) step_b(1, 0, 8'hB0 + 8'(i));
        check("b_full", 32'(full_b), 32'd1);
        check("b_count", 32'(cnt_b), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("b_order", 32'(out_b), 32'(seq_b[i]));
            step_b(0, 1, 8'h00);
        end
        check("b_empty", 32'(empty_b), 32'd1);
        check("b_out0",  32'(out_b),   32'd0);

        // Thresholds: count 0..8..0
        check("c_ae0", 32'(ae_c), 32'd1);
        check("c_af0", 32'(af_c), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step_c(1, 0, 8'(k));
            check("c_up_cnt", 32'(cnt_c), 32'(k));
            check("c_up_ae",  32'(ae_c),  (k <= 2) ? 32'd1 : 32'd0);
            check("c_up_af",  32'(af_c),  (k >= 6) ? 32'd1 : 32'd0);
        end
        check("c_full", 32'(full_c), 32'd1);
        for (int k = 7; k >= 0; k--) begin
            step_c(0, 1, 8'h00);
            check("c_dn_cnt", 32'(cnt_c), 32'(k));
            check("c_dn_ae",  32'(ae_c),  (k <= 2) ? 32'd1 : 32'd0);
            check("c_dn_af",  32'(af_c),  (k >= 6) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
